mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide memory port. It is shared between the instruction-fetch requester (F) and the load/store requester (D). Each granted transaction of 1-4 bytes is split into consecutive byte accesses, and read bytes are assembled into a 32-bit word. Sits between the control unit and the memory; owns Mem_CS, Mem_WR and the memory address.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter and byte sequencer for the shared memory port
// Revision : 1.0 - initial release
// =============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              F_Req,
   input  logic [ADDR_W-1:0] F_Addr,
   input  logic [1:0]        F_Len,
   output logic              F_Gnt,
   output logic              F_Done,
   input  logic              D_Req,
   input  logic              D_Write,
   input  logic [ADDR_W-1:0] D_Addr,
   input  logic [1:0]        D_Len,
   input  logic [31:0]       D_WData,
   output logic              D_Gnt,
   output logic              D_Done,
   output logic [31:0]       RData,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic              Mem_CS,
   output logic              Mem_WR,
   output logic [7:0]        Mem_WData,
   input  logic [7:0]        Mem_RData,
   output logic              Busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              f_gnt_q, f_gnt_d;
   logic              d_gnt_q, d_gnt_d;
   logic              last_d_q, last_d_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              pick_f;
   logic              cap_en;
   logic [1:0]        cap_lane;

   // On contention F wins only when D held the port last
   assign pick_f = F_Req & (~D_Req | last_d_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      f_gnt_d  = f_gnt_q;
      d_gnt_d  = d_gnt_q;
      last_d_d = last_d_q;
      rdata_d  = rdata_q;
      cap_en   = 1'b0;
      cap_lane = 2'd0;

      case (state_q)
         S_IDLE: begin
            if (F_Req | D_Req) begin
               state_d = S_ISSUE;
               cnt_d   = 2'd0;
               rdata_d = 32'd0;
               if (pick_f) begin
                  base_d  = F_Addr;
                  len_d   = F_Len;
                  write_d = 1'b0;
                  wdata_d = 32'd0;
                  f_gnt_d = 1'b1;
               end else begin
                  base_d  = D_Addr;
                  len_d   = D_Len;
                  write_d = D_Write;
                  wdata_d = D_WData;
                  d_gnt_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            // Read data trails its access by one cycle, so lane cnt-1 lands now
            if (!write_q && (cnt_q != 2'd0)) begin
               cap_en   = 1'b1;
               cap_lane = cnt_q - 2'd1;
            end
            if (cnt_q == len_q) begin
               state_d = write_q ? S_DONE : S_CAPTURE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_CAPTURE: begin
            cap_en   = 1'b1;
            cap_lane = len_q;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d  = S_IDLE;
            last_d_d = d_gnt_q;
            f_gnt_d  = 1'b0;
            d_gnt_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (cap_en) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_lane == 2'(i)) begin
               rdata_d[8*i +: 8] = Mem_RData;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         len_q    <= 2'd0;
         base_q   <= '0;
         wdata_q  <= 32'd0;
         write_q  <= 1'b0;
         f_gnt_q  <= 1'b0;
         d_gnt_q  <= 1'b0;
         last_d_q <= 1'b1;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         f_gnt_q  <= f_gnt_d;
         d_gnt_q  <= d_gnt_d;
         last_d_q <= last_d_d;
         rdata_q  <= rdata_d;
      end
   end

   // Port outputs are pure decode of registered state and counter
   assign Mem_CS      = (state_q != S_ISSUE);
   assign Mem_WR      = write_q;
   assign Mem_Address = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
   assign Mem_WData   = wdata_q[{cnt_q, 3'b000} +: 8];
   assign F_Gnt       = f_gnt_q;
   assign D_Gnt       = d_gnt_q;
   assign F_Done      = (state_q == S_DONE) & f_gnt_q;
   assign D_Done      = (state_q == S_DONE) & d_gnt_q;
   assign RData       = rdata_q;
   assign Busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (vectors + random model)
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_port_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        F_Req, F_Gnt, F_Done;
   logic [15:0] F_Addr;
   logic [1:0]  F_Len;
   logic        D_Req, D_Write, D_Gnt, D_Done;
   logic [15:0] D_Addr;
   logic [1:0]  D_Len;
   logic [31:0] D_WData;
   logic [31:0] RData;
   logic [15:0] Mem_Address;
   logic        Mem_CS, Mem_WR, Busy;
   logic [7:0]  Mem_WData;
   logic [7:0]  mem_rdata;

   always #5 Clock = ~Clock;

   mem_port_arbiter #(.ADDR_W(16)) dut (
      .Clock(Clock), .Reset(Reset),
      .F_Req(F_Req), .F_Addr(F_Addr), .F_Len(F_Len), .F_Gnt(F_Gnt), .F_Done(F_Done),
      .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_Len(D_Len),
      .D_WData(D_WData), .D_Gnt(D_Gnt), .D_Done(D_Done), .RData(RData),
      .Mem_Address(Mem_Address), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
      .Mem_WData(Mem_WData), .Mem_RData(mem_rdata), .Busy(Busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int overlap_cnt = 0;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h0010: init_byte = 8'h34;
         16'h0011: init_byte = 8'h12;
         16'hFFFE: init_byte = 8'h11;
         16'hFFFF: init_byte = 8'h22;
         16'h0000: init_byte = 8'h33;
         16'h0001: init_byte = 8'h44;
         16'h0400: init_byte = 8'hA5;
         default:  init_byte = a[7:0] ^ a[15:8] ^ 8'h5C;
      endcase
   endfunction

   // Memory under the port: one-cycle read latency, writes on the access edge
   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:65535];
   bit mem_ready = 1'b0;
   always @(posedge Clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
         mem_ready <= 1'b1;
      end else if (!Mem_CS) begin
         if (Mem_WR) mem[Mem_Address] <= Mem_WData;
         else        mem_rdata <= mem[Mem_Address];
      end
   end

   typedef struct { logic wr; logic [15:0] a; logic [7:0] d; } acc_t;
   acc_t acc_q[$];
   always @(negedge Clock) begin
      if (Mem_CS === 1'b0) acc_q.push_back('{Mem_WR, Mem_Address, Mem_WData});
      if (F_Gnt && D_Gnt) overlap_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [15:0] a, input logic [1:0] len);
      logic [31:0] r;
      logic [15:0] p;
      r = 32'd0;
      for (int i = 0; i <= 3; i++) begin
         p = a + 16'(i);
         if (i <= int'(len)) r[8*i +: 8] = ref_mem[p];
      end
      return r;
   endfunction

   // One complete transaction; checks the byte-access trace against the spec rules
   task automatic run_txn(input string tag, input bit is_f, input bit wr,
                          input logic [15:0] addr, input logic [1:0] len,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
      bit          done_seen;
      bit          eff_wr;
      logic [15:0] p;
      @(negedge Clock);
      acc_q.delete();
      eff_wr = is_f ? 1'b0 : wr;
      if (is_f) begin
         F_Req = 1'b1; F_Addr = addr; F_Len = len;
      end else begin
         D_Req = 1'b1; D_Write = wr; D_Addr = addr; D_Len = len; D_WData = wd;
      end
      lat = 0; done_seen = 1'b0; rd = 32'd0;
      while (!done_seen && lat < 20) begin
         @(negedge Clock);
         lat++;
         if (is_f ? F_Done : D_Done) begin
            done_seen = 1'b1;
         end else begin
            F_Addr = 16'($urandom); F_Len = 2'($urandom);
            D_Addr = 16'($urandom); D_Len = 2'($urandom);
            D_WData = $urandom; D_Write = 1'($urandom);
         end
      end
      chk({tag, " done_seen"}, 64'(done_seen), 64'd1);
      F_Req = 1'b0; D_Req = 1'b0;
      if (!done_seen) return;
      rd = RData;
      chk({tag, " own_gnt"},    64'(is_f ? F_Gnt : D_Gnt), 64'd1);
      chk({tag, " other_gnt"},  64'(is_f ? D_Gnt : F_Gnt), 64'd0);
      chk({tag, " other_done"}, 64'(is_f ? D_Done : F_Done), 64'd0);
      chk({tag, " n_access"}, 64'(acc_q.size()), 64'(int'(len) + 1));
      for (int i = 0; i < acc_q.size() && i < 4; i++) begin
         p = addr + 16'(i);
         chk($sformatf("%s acc%0d wr", tag, i),   64'(acc_q[i].wr), 64'(eff_wr));
         chk($sformatf("%s acc%0d addr", tag, i), 64'(acc_q[i].a),  64'(p));
         if (eff_wr) chk($sformatf("%s acc%0d data", tag, i), 64'(acc_q[i].d), 64'(wd[8*i +: 8]));
      end
      if (eff_wr) begin
         for (int i = 0; i <= int'(len); i++) begin
            p = addr + 16'(i);
            ref_mem[p] = wd[8*i +: 8];
            chk($sformatf("%s mem%0d", tag, i), 64'(mem[p]), 64'(ref_mem[p]));
         end
      end
   endtask

   typedef struct {
      string       name;
      bit          is_f;
      bit          wr;
      logic [15:0] addr;
      logic [1:0]  len;
      logic [31:0] wd;
      int          exp_lat;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vecs[8];

   int          lat, w, idle;
   logic [31:0] rd, exp_rd;
   bit          got, isf, wr, f_dropped;
   logic [15:0] ra;
   logic [1:0]  rl;
   logic [31:0] rw;

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
      vecs[0] = '{"f_rd_0010",  1'b1, 1'b0, 16'h0010, 2'd1, 32'h0,        4, 1'b1, 32'h0000_1234};
      vecs[1] = '{"d_wr_0100",  1'b0, 1'b1, 16'h0100, 2'd3, 32'hAABBCCDD, 5, 1'b0, 32'h0};
      vecs[2] = '{"d_rd_wrap",  1'b0, 1'b0, 16'hFFFE, 2'd3, 32'h0,        6, 1'b1, 32'h4433_2211};
      vecs[3] = '{"d_rd_0100",  1'b0, 1'b0, 16'h0100, 2'd3, 32'h0,        6, 1'b1, 32'hAABB_CCDD};
      vecs[4] = '{"f_rd_1byte", 1'b1, 1'b0, 16'h0011, 2'd0, 32'h0,        3, 1'b1, 32'h0000_0012};
      vecs[5] = '{"d_rd_0102",  1'b0, 1'b0, 16'h0102, 2'd1, 32'h0,        4, 1'b1, 32'h0000_AABB};
      vecs[6] = '{"d_wr_wrap",  1'b0, 1'b1, 16'hFFFF, 2'd1, 32'h0000_5A5B, 3, 1'b0, 32'h0};
      vecs[7] = '{"f_rd_wrap",  1'b1, 1'b0, 16'hFFFF, 2'd1, 32'h0,        4, 1'b1, 32'h0000_5A5B};

      Reset = 1'b0; F_Req = 1'b0; D_Req = 1'b0; D_Write = 1'b0;
      F_Addr = '0; F_Len = '0; D_Addr = '0; D_Len = '0; D_WData = '0;
      repeat (3) @(negedge Clock);
      chk("rst Mem_CS", 64'(Mem_CS), 64'd1);
      chk("rst Mem_WR", 64'(Mem_WR), 64'd0);
      chk("rst Mem_Address", 64'(Mem_Address), 64'd0);
      chk("rst Mem_WData", 64'(Mem_WData), 64'd0);
      chk("rst gnts", 64'({F_Gnt, D_Gnt}), 64'd0);
      chk("rst dones", 64'({F_Done, D_Done}), 64'd0);
      chk("rst RData", 64'(RData), 64'd0);
      chk("rst Busy", 64'(Busy), 64'd0);
      Reset = 1'b1;

      for (int v = 0; v < 8; v++) begin
         run_txn(vecs[v].name, vecs[v].is_f, vecs[v].wr, vecs[v].addr, vecs[v].len,
                 vecs[v].wd, lat, rd);
         chk({vecs[v].name, " latency"}, 64'(lat), 64'(vecs[v].exp_lat));
         if (vecs[v].chk_rd) chk({vecs[v].name, " RData"}, 64'(rd), 64'(vecs[v].exp_rd));
      end

      // Round robin with both requesters continuously asking, starting from reset
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      F_Req = 1'b1; F_Addr = 16'h0200; F_Len = 2'd0;
      D_Req = 1'b1; D_Write = 1'b0; D_Addr = 16'h0300; D_Len = 2'd0;
      f_dropped = 1'b0;
      for (int t = 0; t < 4; t++) begin
         w = 0; idle = 0; got = 1'b0;
         while (!got && w < 20) begin
            @(negedge Clock);
            w++;
            if (!Busy) idle++;
            if (w == 1 && t > 0) begin
               if (f_dropped) F_Req = 1'b1; else D_Req = 1'b1;
            end
            if (F_Done || D_Done) got = 1'b1;
         end
         chk($sformatf("rr%0d done_seen", t), 64'(got), 64'd1);
         chk($sformatf("rr%0d winner_is_f", t), 64'(F_Done), 64'((t % 2) == 0));
         chk($sformatf("rr%0d cycles", t), 64'(w), 64'(t == 0 ? 3 : 4));
         chk($sformatf("rr%0d idle", t), 64'(idle), 64'(t == 0 ? 0 : 1));
         f_dropped = F_Done;
         if (F_Done) F_Req = 1'b0; else D_Req = 1'b0;
      end
      F_Req = 1'b0; D_Req = 1'b0;

      // Reset in the third ISSUE cycle of a 4-byte read aborts it cleanly
      repeat (2) @(negedge Clock);
      D_Req = 1'b1; D_Write = 1'b0; D_Addr = 16'h0400; D_Len = 2'd3;
      repeat (3) @(negedge Clock);
      chk("abort in_issue", 64'(Mem_CS), 64'd0);
      chk("abort partial_rdata", 64'(RData[7:0]), 64'hA5);
      F_Req = 1'b1; F_Addr = 16'h0010; F_Len = 2'd1;
      Reset = 1'b0;
      #1;
      chk("abort Mem_CS", 64'(Mem_CS), 64'd1);
      chk("abort gnts", 64'({F_Gnt, D_Gnt}), 64'd0);
      chk("abort RData", 64'(RData), 64'd0);
      chk("abort Busy", 64'(Busy), 64'd0);
      @(negedge Clock);
      chk("abort no_done", 64'({F_Done, D_Done}), 64'd0);
      Reset = 1'b1;
      @(negedge Clock);
      chk("abort f_wins", 64'({F_Gnt, D_Gnt}), 64'b10);
      w = 1; got = 1'b0;
      while (!got && w < 20) begin
         @(negedge Clock);
         w++;
         chk("abort no_d_done", 64'(D_Done), 64'd0);
         if (F_Done) got = 1'b1;
      end
      chk("abort f_done_seen", 64'(got), 64'd1);
      chk("abort f_latency", 64'(w), 64'd4);
      chk("abort f_RData", 64'(RData), 64'h0000_1234);
      F_Req = 1'b0; D_Req = 1'b0;

      // Randomized transactions against the reference memory model
      for (int n = 0; n < 40; n++) begin
         isf = 1'($urandom_range(0, 1));
         wr  = isf ? 1'b0 : 1'($urandom_range(0, 1));
         ra  = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                           : 16'($urandom);
         rl  = 2'($urandom);
         rw  = $urandom;
         exp_rd = model_read(ra, rl);
         run_txn($sformatf("rnd%0d", n), isf, wr, ra, rl, rw, lat, rd);
         chk($sformatf("rnd%0d latency", n), 64'(lat), 64'(int'(rl) + (wr ? 2 : 3)));
         if (!wr) chk($sformatf("rnd%0d RData", n), 64'(rd), 64'(exp_rd));
      end

      chk("gnt overlap", 64'(overlap_cnt), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
